// File: rtl/uart_hex_formatter_if.sv
// Word handshake between the memory-dump source and the hex formatter.
interface uart_hex_formatter_if;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_address;
  logic [31:0] word_data;
  logic        word_mismatch;

  modport master (output word_valid, word_address, word_data, word_mismatch,
                  input  word_ready);
  modport slave  (input  word_valid, word_address, word_data, word_mismatch,
                  output word_ready);
endinterface

// File: rtl/uart_hex_formatter.sv
// Formats address/data/flag words as ASCII hex lines into a UART TX FIFO,
// plus an "END <words> <mismatches>" summary line on request.
module uart_hex_formatter #(
  parameter int COUNT_WIDTH = 16,
  parameter bit EMIT_CR     = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_hex_formatter_if.slave  wb,
  input  logic                 finish,
  output logic                 busy,
  input  logic                 uart_full,
  output logic                 uart_write,
  output logic [7:0]           uart_data
);

  localparam int D   = COUNT_WIDTH / 4;
  localparam int EOL = EMIT_CR ? 2 : 1;
  localparam logic [7:0] LINE_LEN = 8'(19 + EOL);
  localparam logic [7:0] SUM_LEN  = 8'(5 + 2 * D + EOL);

  typedef enum logic [1:0] {IDLE, LINE, SUMMARY} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             idx_q, idx_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   flag_q, flag_d;
  logic                   pend_q, pend_d;
  logic [COUNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [COUNT_WIDTH-1:0] mcnt_q, mcnt_d;
  logic                   uart_write_q, uart_write_d;
  logic [7:0]             uart_data_q, uart_data_d;
  logic [7:0]             char_c;
  int                     ci;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign wb.word_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE) | pend_q;
  assign uart_write    = uart_write_q;
  assign uart_data     = uart_data_q;

  // Character selected by the current index within the active line.
  always_comb begin
    char_c = 8'h00;
    ci     = int'(idx_q);
    if (state_q == LINE) begin
      if (ci < 8)        char_c = hex_char(addr_q[4*(7-ci) +: 4]);
      else if (ci == 8)  char_c = 8'h3A;
      else if (ci < 17)  char_c = hex_char(data_q[4*(16-ci) +: 4]);
      else if (ci == 17) char_c = 8'h20;
      else if (ci == 18) char_c = flag_q ? 8'h46 : 8'h50;
      else if (ci == 19 && EMIT_CR) char_c = 8'h0D;
      else               char_c = 8'h0A;
    end else if (state_q == SUMMARY) begin
      if (ci == 0)              char_c = 8'h45;
      else if (ci == 1)         char_c = 8'h4E;
      else if (ci == 2)         char_c = 8'h44;
      else if (ci == 3)         char_c = 8'h20;
      else if (ci < 4 + D)      char_c = hex_char(wcnt_q[4*(D+3-ci) +: 4]);
      else if (ci == 4 + D)     char_c = 8'h20;
      else if (ci < 5 + 2 * D)  char_c = hex_char(mcnt_q[4*(2*D+4-ci) +: 4]);
      else if (ci == 5 + 2 * D && EMIT_CR) char_c = 8'h0D;
      else                      char_c = 8'h0A;
    end
  end

  // Next-state: accept words, pace writes one per two cycles, track counters.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    data_d       = data_q;
    flag_d       = flag_q;
    pend_d       = pend_q;
    wcnt_d       = wcnt_q;
    mcnt_d       = mcnt_q;
    uart_write_d = 1'b0;
    uart_data_d  = uart_data_q;
    case (state_q)
      IDLE: begin
        if (wb.word_valid) begin
          addr_d  = wb.word_address;
          data_d  = wb.word_data;
          flag_d  = wb.word_mismatch;
          idx_d   = 8'd0;
          state_d = LINE;
          if (!(&wcnt_q)) wcnt_d = wcnt_q + 1'b1;
          if (wb.word_mismatch && !(&mcnt_q)) mcnt_d = mcnt_q + 1'b1;
        end else if (pend_q) begin
          idx_d   = 8'd0;
          pend_d  = 1'b0;
          state_d = SUMMARY;
        end
      end
      LINE, SUMMARY: begin
        // A write cycle is always followed by an idle cycle so the FIFO full
        // flag seen at the next edge reflects the character just written.
        if (uart_write_q) begin
          if (idx_q == ((state_q == LINE) ? LINE_LEN : SUM_LEN)) state_d = IDLE;
        end else if (!uart_full) begin
          uart_write_d = 1'b1;
          uart_data_d  = char_c;
          idx_d        = idx_q + 8'd1;
          if (state_q == SUMMARY && idx_q == SUM_LEN - 8'd1) begin
            wcnt_d = '0;
            mcnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A finish seen while the summary is running (or starting) is dropped.
    if (finish && state_q != SUMMARY && state_d != SUMMARY) pend_d = 1'b1;
  end

  // State and datapath registers; reset discards any partial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= 8'd0;
      addr_q       <= '0;
      data_q       <= '0;
      flag_q       <= 1'b0;
      pend_q       <= 1'b0;
      wcnt_q       <= '0;
      mcnt_q       <= '0;
      uart_write_q <= 1'b0;
      uart_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      flag_q       <= flag_d;
      pend_q       <= pend_d;
      wcnt_q       <= wcnt_d;
      mcnt_q       <= mcnt_d;
      uart_write_q <= uart_write_d;
      uart_data_q  <= uart_data_d;
    end
  end

endmodule
